wb_regfile: RTL

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_pkg.sv | 17 +
 rtl/load_extend.sv | 37 +++
 rtl/wb_regfile.sv | 89 ++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: writeback source selects and load funct3 codes.
package wb_pkg;

    typedef enum logic [1:0] {
        RW_ALU_MEM = 2'd0,
        RW_PC_IMM  = 2'd1,
        RW_PC_FOUR = 2'd2,
        RW_IMM     = 2'd3
    } rwsel_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Extracts and sign/zero-extends the addressed byte or half from an aligned memory word.
module load_extend
    import wb_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        byte_sel = word[7:0];
        case (off)
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = off[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        value = word;
        case (funct3)
            LB:      value = {{24{byte_sel[7]}}, byte_sel};
            LH:      value = {{16{half_sel[15]}}, half_sel};
            LBU:     value = {24'h0, byte_sel};
            LHU:     value = {16'h0, half_sel};
            default: value = word;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback mux, 31-entry integer register file with optional write-to-read bypass,
// and retired-instruction counter.
module wb_regfile
    import wb_pkg::*;
#(
    parameter int BYPASS    = 1,
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 RegWrite,
    input  logic                 MemtoReg,
    input  logic [1:0]           RWSel,
    input  logic [31:0]          Pc_Imm,
    input  logic [31:0]          Pc_Four,
    input  logic [31:0]          Imm_Out,
    input  logic [31:0]          Alu_Result,
    input  logic [31:0]          MemReadData,
    input  logic [4:0]           rd,
    input  logic [31:0]          Curr_Instr,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    output logic [31:0]          rd1,
    output logic [31:0]          rd2,
    output logic [31:0]          wb_data,
    output logic                 wb_en,
    output logic [4:0]           wb_rd,
    output logic [INSTRET_W-1:0] instret
);

    logic [31:0] regs [1:31];
    logic [31:0] load_value;

    load_extend u_load_extend (
        .word   (MemReadData),
        .funct3 (Curr_Instr[14:12]),
        .off    (Alu_Result[1:0]),
        .value  (load_value)
    );

    always_comb begin
        wb_data = Alu_Result;
        case (rwsel_e'(RWSel))
            RW_ALU_MEM: wb_data = MemtoReg ? load_value : Alu_Result;
            RW_PC_IMM:  wb_data = Pc_Imm;
            RW_PC_FOUR: wb_data = Pc_Four;
            RW_IMM:     wb_data = Imm_Out;
            default:    wb_data = Alu_Result;
        endcase
    end

    // x0 is never written, which also keeps it out of the bypass path.
    assign wb_en = RegWrite && (rd != 5'd0);
    assign wb_rd = rd;

    // NOTE: the array is plain flops rather than a RAM, so it can and must be cleared by the async reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < 32; i++) regs[i] <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (wb_en && rd == 5'(i)) regs[i] <= wb_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instret <= '0;
        end else if (Curr_Instr != 32'h0) begin
            instret <= instret + INSTRET_W'(1);
        end
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int i = 1; i < 32; i++) begin
            if (rs1 == 5'(i)) rd1 = regs[i];
            if (rs2 == 5'(i)) rd2 = regs[i];
        end
        // A write held off by reset never lands, so it must not be forwarded either.
        if (BYPASS != 0 && reset_n && wb_en) begin
            if (rs1 == rd) rd1 = wb_data;
            if (rs2 == rd) rd2 = wb_data;
        end
    end

endmodule
